// File: rtl/cmd_link_tx.sv
// Transmitter end of the motor command link: drives state/amount lines, strobes
// candyflag and runs a four-phase handshake on the far end's acknowledge with timeout and retry.
module cmd_link_tx #(
    parameter int SETUP_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 2080,
    parameter int MAX_RETRY      = 2,
    parameter int CW             = 16
) (
    input  logic       clk,
    input  logic       rst,
    // Command handshake: a command moves on any clk edge where cmd_valid and
    // cmd_ready are both high; cmd_ready is high only while idle, and offers
    // made while busy are dropped, never queued.
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_state,
    input  logic [1:0] cmd_amount,
    output logic [2:0] teststate_o,
    output logic [1:0] stateamount_o,
    output logic       candyflag_o,
    input  logic       handshake_i,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] fsm_state
);

    localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [CW-1:0] SETUP_CNT    = CW'(SETUP_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_CNT  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retry;
    logic [RW-1:0] retry_next;
    logic          ack_meta;
    logic          ack_s;

    assign retry_next = retry + RW'(1);

    // The far end's acknowledge is asynchronous to osc_clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= handshake_i;
            ack_s    <= ack_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            retry         <= '0;
            teststate_o   <= 3'b000;
            stateamount_o <= 2'b00;
            candyflag_o   <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        teststate_o   <= cmd_state;
                        stateamount_o <= cmd_amount;
                        cnt           <= '0;
                        retry         <= '0;
                        state         <= SETUP;
                    end
                end
                SETUP: begin
                    // A stale ack still high from the previous exchange holds off the strobe.
                    if (cnt >= SETUP_CNT && !ack_s) begin
                        candyflag_o <= 1'b1;
                        cnt         <= '0;
                        state       <= STROBE;
                    end else if (cnt == TIMEOUT_CNT) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STROBE: begin
                    if (ack_s) begin
                        candyflag_o <= 1'b0;
                        cnt         <= '0;
                        state       <= RELEASE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        candyflag_o <= 1'b0;
                        cnt         <= '0;
                        retry       <= retry_next;
                        if (retry_next == RETRY_LIMIT) begin
                            error <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= SETUP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_cmd_link_tx.sv
// Bench for cmd_link_tx: a phase-by-phase transaction model checked every cycle,
// plus directed scenarios with hand-computed latencies.
module tb_cmd_link_tx;

    localparam int SETUP_CYCLES   = 4;
    localparam int TIMEOUT_CYCLES = 2080;
    localparam int MAX_RETRY      = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_state = 3'b000;
    logic [1:0] cmd_amount = 2'b00;
    logic       handshake_i = 1'b0;
    logic       cmd_ready;
    logic [2:0] teststate_o;
    logic [1:0] stateamount_o;
    logic       candyflag_o;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] fsm_state;

    cmd_link_tx #(
        .SETUP_CYCLES(SETUP_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MAX_RETRY(MAX_RETRY),
        .CW(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_state(cmd_state),
        .cmd_amount(cmd_amount),
        .teststate_o(teststate_o),
        .stateamount_o(stateamount_o),
        .candyflag_o(candyflag_o),
        .handshake_i(handshake_i),
        .busy(busy),
        .done(done),
        .error(error),
        .fsm_state(fsm_state)
    );

    // clock / cycle count
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // expected outputs after the most recent edge
    logic [2:0] e_state = 3'b000;
    logic [1:0] e_amt = 2'b00;
    logic       e_flag = 1'b0;
    logic       e_busy = 1'b0;
    logic       e_done = 1'b0;
    logic       e_err = 1'b0;
    bit         ack_h[$];

    int checks = 0;
    int errors = 0;
    int nprint = 0;
    int n_done = 0;
    int n_err  = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit hit(input int sel);
        case (sel)
            0: return candyflag_o === 1'b1;
            1: return candyflag_o === 1'b0;
            2: return done === 1'b1;
            default: return error === 1'b1;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int budget, input string nm);
        int n;
        n = 0;
        while (!hit(sel) && n < budget) begin
            tick();
            n++;
        end
        if (!hit(sel)) begin
            checks++;
            errors++;
            $display("FAIL %s: event absent after %0d cycles, required within budget", nm, budget);
        end
    endtask

    task automatic do_cmd(input logic [2:0] st, input logic [1:0] amt);
        tick();
        cmd_valid  = 1'b1;
        cmd_state  = st;
        cmd_amount = amt;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Model: one edge of time; ack seen by the link is the line as it stood two edges earlier.
    task automatic m_step(output bit aborted);
        @(posedge clk);
        ack_h.push_back(rst ? 1'b0 : handshake_i);
        void'(ack_h.pop_front());
        e_done  = 1'b0;
        e_err   = 1'b0;
        aborted = rst;
        if (rst) begin
            foreach (ack_h[i]) ack_h[i] = 1'b0;
            e_state = 3'b000;
            e_amt   = 2'b00;
            e_flag  = 1'b0;
            e_busy  = 1'b0;
        end
    endtask

    function automatic bit m_ack();
        return ack_h[0];
    endfunction

    task automatic m_txn();
        bit ab;
        bit acked;
        int k;
        int tries;
        tries = 0;
        forever begin
            // bus settles for SETUP_CYCLES, then strobe once ack is seen low
            k = 0;
            forever begin
                m_step(ab);
                if (ab) return;
                k++;
                if (k > SETUP_CYCLES && !m_ack()) begin
                    e_flag = 1'b1;
                    break;
                end
                if (k > TIMEOUT_CYCLES) begin
                    e_err  = 1'b1;
                    e_busy = 1'b0;
                    return;
                end
            end
            acked = 1'b0;
            for (k = 1; k <= TIMEOUT_CYCLES; k++) begin
                m_step(ab);
                if (ab) return;
                if (m_ack()) begin
                    acked = 1'b1;
                    break;
                end
            end
            e_flag = 1'b0;
            if (acked) begin
                for (k = 1; k <= TIMEOUT_CYCLES; k++) begin
                    m_step(ab);
                    if (ab) return;
                    if (!m_ack()) begin
                        e_done = 1'b1;
                        e_busy = 1'b0;
                        return;
                    end
                    if (k == TIMEOUT_CYCLES) begin
                        e_err  = 1'b1;
                        e_busy = 1'b0;
                        return;
                    end
                end
            end
            tries++;
            if (tries == MAX_RETRY) begin
                e_err  = 1'b1;
                e_busy = 1'b0;
                return;
            end
        end
    endtask

    task automatic model_loop();
        bit ab;
        forever begin
            m_step(ab);
            if (!ab && cmd_valid) begin
                e_state = cmd_state;
                e_amt   = cmd_amount;
                e_busy  = 1'b1;
                m_txn();
            end
        end
    endtask

    // scoreboard: every cycle, all outputs against the model
    task automatic compare_loop();
        logic [9:0] got;
        logic [9:0] want;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                got  = {teststate_o, stateamount_o, candyflag_o, busy, done, error, cmd_ready};
                want = {e_state, e_amt, e_flag, e_busy, e_done, e_err, !rst && !e_busy};
                checks++;
                if (got !== want) begin
                    errors++;
                    if (nprint < 20) begin
                        nprint++;
                        $display("FAIL model cycle %0d: got %b want %b (state,amt,flag,busy,done,err,ready)",
                                 cyc, got, want);
                    end
                end
                if (done === 1'b1) n_done++;
                if (error === 1'b1) n_err++;
            end
        end
    endtask

    initial begin
        int t0;
        int ta;
        int r1;
        int f1;
        int base_err;
        int base_done;
        for (int i = 0; i < 3; i++) ack_h.push_back(1'b0);
        fork
            model_loop();
            compare_loop();
        join_none

        // reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_flag", 32'(candyflag_o), 0);
        chk("rst_bus", 32'({teststate_o, stateamount_o}), 0);
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();
        chk("idle_ready", 32'(cmd_ready), 1);

        // nominal handshake
        base_err = n_err;
        do_cmd(3'b101, 2'b10);
        t0 = cyc;
        chk("t1_bus", 32'({teststate_o, stateamount_o}), 32'b101_10);
        chk("t1_busy", 32'(busy), 1);
        wait_for(0, 50, "t1_rise");
        chk("t1_rise_lat", cyc - t0, 5);
        repeat (5) tick();
        handshake_i = 1'b1;
        ta = cyc;
        wait_for(1, 50, "t1_fall");
        chk("t1_fall_lat", cyc - ta, 3);
        repeat (5) tick();
        handshake_i = 1'b0;
        ta = cyc;
        wait_for(2, 50, "t1_done");
        chk("t1_done_lat", cyc - ta, 3);
        chk("t1_ready_at_done", 32'(cmd_ready), 1);
        tick();
        chk("t1_done_width", 32'(done), 0);
        chk("t1_no_error", n_err - base_err, 0);

        // single retry
        base_err = n_err;
        do_cmd(3'b110, 2'b01);
        wait_for(0, 50, "t2_rise1");
        r1 = cyc;
        wait_for(1, 2200, "t2_fall1");
        f1 = cyc;
        chk("t2_strobe_len", f1 - r1, 2080);
        wait_for(0, 50, "t2_rise2");
        chk("t2_gap", cyc - f1, 5);
        handshake_i = 1'b1;
        wait_for(1, 50, "t2_fall2");
        handshake_i = 1'b0;
        wait_for(2, 50, "t2_done");
        chk("t2_done", 32'(done), 1);
        chk("t2_no_error", n_err - base_err, 0);
        repeat (3) tick();

        // exhausted retries
        base_err = n_err;
        do_cmd(3'b101, 2'b10);
        wait_for(0, 50, "t3_rise1");
        r1 = cyc;
        wait_for(1, 2200, "t3_fall1");
        f1 = cyc;
        chk("t3_strobe1_len", f1 - r1, 2080);
        wait_for(0, 50, "t3_rise2");
        r1 = cyc;
        wait_for(1, 2200, "t3_fall2");
        chk("t3_strobe2_len", cyc - r1, 2080);
        chk("t3_error", 32'(error), 1);
        chk("t3_no_done", 32'(done), 0);
        tick();
        chk("t3_error_width", 32'(error), 0);
        chk("t3_idle", 32'({busy, cmd_ready}), 32'b01);
        chk("t3_bus_held", 32'({teststate_o, stateamount_o}), 32'b101_10);
        chk("t3_one_error", n_err - base_err, 1);

        // stuck ack
        base_done = n_done;
        do_cmd(3'b010, 2'b11);
        wait_for(0, 50, "t4_rise");
        handshake_i = 1'b1;
        wait_for(1, 50, "t4_fall");
        f1 = cyc;
        wait_for(3, 2200, "t4_error");
        chk("t4_error_lat", cyc - f1, 2080);
        chk("t4_flag_low", 32'(candyflag_o), 0);
        chk("t4_no_done", n_done - base_done, 0);
        handshake_i = 1'b0;
        repeat (4) tick();

        // stale ack and busy ignore
        handshake_i = 1'b1;
        repeat (4) tick();
        do_cmd(3'b001, 2'b01);
        tick();
        tick();
        cmd_valid  = 1'b1;
        cmd_state  = 3'b011;
        cmd_amount = 2'b00;
        tick();
        cmd_valid = 1'b0;
        chk("t5_bus_kept", 32'({teststate_o, stateamount_o}), 32'b001_01);
        repeat (8) tick();
        chk("t5_flag_held_off", 32'(candyflag_o), 0);
        handshake_i = 1'b0;
        ta = cyc;
        wait_for(0, 50, "t5_rise");
        chk("t5_rise_lat", cyc - ta, 3);
        chk("t5_bus_still", 32'({teststate_o, stateamount_o}), 32'b001_01);
        repeat (2) tick();
        handshake_i = 1'b1;
        wait_for(1, 50, "t5_fall");
        handshake_i = 1'b0;
        wait_for(2, 50, "t5_done");
        repeat (2) tick();

        // reset mid-strobe
        do_cmd(3'b111, 2'b11);
        wait_for(0, 50, "t6_rise");
        repeat (3) tick();
        base_done = n_done;
        base_err  = n_err;
        rst = 1'b1;
        tick();
        chk("t6_flag", 32'(candyflag_o), 0);
        chk("t6_bus", 32'({teststate_o, stateamount_o}), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_pulses", 32'({done, error}), 0);
        rst = 1'b0;
        repeat (10) tick();
        chk("t6_no_done", n_done - base_done, 0);
        chk("t6_no_error", n_err - base_err, 0);
        chk("t6_ready", 32'(cmd_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
